// File: rtl/dibit_pkg.sv
// Shared line-symbol constants and FSM state type for the dibit link (tx and rx).
package dibit_pkg;

    localparam logic [1:0] SYM_00 = 2'b00;
    localparam logic [1:0] SYM_01 = 2'b01;
    localparam logic [1:0] SYM_10 = 2'b10;
    localparam logic [1:0] SYM_11 = 2'b11;

    localparam logic [1:0] PREAMBLE_SYM = SYM_11;
    localparam logic [1:0] IDLE_SYM     = SYM_00;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        DATA,
        PAR
    } state_t;

    // Parity line symbol: 01 when the byte carries an odd number of ones.
    function automatic logic [1:0] parity_sym(input logic [7:0] d);
        return {1'b0, ^d};
    endfunction

endpackage

// File: rtl/dibit_sym_timer.sv
// Symbol hold timer: sym_end pulses on the last cycle of each DIV-cycle symbol.
// Latency: sym_end asserts DIV-1 cycles after the start edge; start reloads mid-count.
// Backpressure: none; start is taken every cycle it is asserted.
module dibit_sym_timer #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic sym_end
);

    localparam int             CW     = $clog2(DIV + 1);
    localparam logic [CW-1:0]  RELOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt;
    logic          active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            cnt    <= RELOAD;
            active <= 1'b1;
        end else if (active) begin
            if (cnt == '0)
                active <= 1'b0;
            else
                cnt <= cnt - CW'(1);
        end
    end

    assign sym_end = active && (cnt == '0);

endmodule

// File: rtl/dibit_tx.sv
// Byte-to-dibit serializer: preamble 11, four MSB-first data dibits, optional parity
// (DIBIT_TX_PARITY_EN). Line shows 11 the cycle after the accept edge, each symbol held DIV cycles.
// Backpressure: in_ready only in IDLE; in_valid/in_data are ignored while a frame is in flight.
module dibit_tx
    import dibit_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       x,
    output logic       z,
    output logic       busy,
    output logic       done
);

    state_t     state;
    logic [7:0] shreg;
    logic [1:0] dib_cnt;
    logic [1:0] line;
    logic       sym_end;
    logic       last_sym;
    logic       frame_end;
    logic       tmr_start;
`ifdef DIBIT_TX_PARITY_EN
    logic [1:0] par_sym;
`endif

    always_comb begin
        last_sym = 1'b0;
`ifdef DIBIT_TX_PARITY_EN
        last_sym = (state == PAR);
`else
        last_sym = (state == DATA) && (dib_cnt == 2'd3);
`endif
        frame_end = sym_end && last_sym;
        // Reload on accept and on every symbol boundary that is not the end of the frame.
        tmr_start = ((state == IDLE) && in_valid) ||
                    ((state != IDLE) && sym_end && !last_sym);
    end

    dibit_sym_timer #(.DIV(DIV)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .start   (tmr_start),
        .sym_end (sym_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            dib_cnt  <= '0;
            line     <= IDLE_SYM;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef DIBIT_TX_PARITY_EN
            par_sym  <= SYM_00;
`endif
        end else begin
            done <= 1'b0;
            if (frame_end) begin
                state    <= IDLE;
                line     <= IDLE_SYM;
                dib_cnt  <= '0;
                in_ready <= 1'b1;
                busy     <= 1'b0;
                done     <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (in_valid) begin
                            shreg    <= in_data;
                            state    <= PRE;
                            line     <= PREAMBLE_SYM;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
`ifdef DIBIT_TX_PARITY_EN
                            par_sym  <= parity_sym(in_data);
`endif
                        end
                    end
                    PRE: begin
                        if (sym_end) begin
                            line    <= shreg[7:6];
                            shreg   <= {shreg[5:0], 2'b00};
                            dib_cnt <= '0;
                            state   <= DATA;
                        end
                    end
                    DATA: begin
                        if (sym_end) begin
                            dib_cnt <= dib_cnt + 2'd1;
`ifdef DIBIT_TX_PARITY_EN
                            if (dib_cnt == 2'd3) begin
                                state <= PAR;
                                line  <= par_sym;
                            end else begin
                                line  <= shreg[7:6];
                                shreg <= {shreg[5:0], 2'b00};
                            end
`else
                            line  <= shreg[7:6];
                            shreg <= {shreg[5:0], 2'b00};
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign x = line[1];
    assign z = line[0];

endmodule

// File: tb/tb_dibit_tx.sv
// Scoreboarded bench for dibit_tx: instance 0 runs DIV=4, instance 1 runs DIV=1.
module tb_dibit_tx;

    typedef struct packed {
        logic [1:0] line;
        logic       done;
        logic       busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] iv;
    logic [7:0] idat [2];
    wire  [1:0] xo, zo, rdy, bsy, dn;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dibit_tx #(.DIV(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(idat[0]),
        .in_ready(rdy[0]), .x(xo[0]), .z(zo[0]), .busy(bsy[0]), .done(dn[0])
    );

    dibit_tx #(.DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(idat[1]),
        .in_ready(rdy[1]), .x(xo[1]), .z(zo[1]), .busy(bsy[1]), .done(dn[1])
    );

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int div_of(input int idx);
        return (idx == 0) ? 4 : 1;
    endfunction

    task automatic push(input int idx, input exp_t e);
        if (idx == 0) q0.push_back(e);
        else          q1.push_back(e);
    endtask

    // Expected per-cycle line/done/busy for one whole frame plus its done cycle.
    task automatic push_frame(input int idx, input logic [7:0] b);
        int         d = div_of(idx);
        logic [7:0] s = b;
        repeat (d) push(idx, '{2'b11, 1'b0, 1'b1});
        for (int i = 0; i < 4; i++) begin
            repeat (d) push(idx, '{s[7:6], 1'b0, 1'b1});
            s = s << 2;
        end
`ifdef DIBIT_TX_PARITY_EN
        repeat (d) push(idx, '{{1'b0, ^b}, 1'b0, 1'b1});
`endif
        push(idx, '{2'b00, 1'b1, 1'b0});
    endtask

    task automatic push_idle(input int idx, input int n);
        repeat (n) push(idx, '{2'b00, 1'b0, 1'b0});
    endtask

    function automatic int qsize(input int idx);
        return (idx == 0) ? q0.size() : q1.size();
    endfunction

    // Advance one cycle, sample 1 time unit after the edge, compare against the next entry.
    task automatic step(input int idx, input string tag, output exp_t e);
        @(posedge clk);
        #1;
        e = (idx == 0) ? q0.pop_front() : q1.pop_front();
        cmp($sformatf("%s line", tag), {6'd0, xo[idx], zo[idx]}, {6'd0, e.line});
        cmp($sformatf("%s done", tag), {7'd0, dn[idx]}, {7'd0, e.done});
        cmp($sformatf("%s busy", tag), {7'd0, bsy[idx]}, {7'd0, e.busy});
        cmp($sformatf("%s in_ready", tag), {7'd0, rdy[idx]}, {7'd0, ~e.busy});
    endtask

    initial begin
        exp_t e;
        int   c;
        int   nbusy;
        int   d1;
        int   d2;
        int   nfr;

        iv      = 2'b00;
        idat[0] = 8'h00;
        idat[1] = 8'h00;
        rst     = 1'b1;

        // Reset state of both instances
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            cmp("reset line", {6'd0, xo[i], zo[i]}, 8'h00);
            cmp("reset in_ready", {7'd0, rdy[i]}, 8'h01);
            cmp("reset busy", {7'd0, bsy[i]}, 8'h00);
            cmp("reset done", {7'd0, dn[i]}, 8'h00);
        end
        rst = 1'b0;

        // DIV=4, 0xB4 with idle lead-in; busy must last exactly 20 cycles
        push_idle(0, 2);
        repeat (2) step(0, "idle", e);
        idat[0] = 8'hB4;
        iv[0]   = 1'b1;
        push_frame(0, 8'hB4);
        nbusy = 0;
        while (q0.size() > 0) begin
            step(0, "b4", e);
            iv[0] = 1'b0;
            nbusy += int'(bsy[0]);
        end
`ifdef DIBIT_TX_PARITY_EN
        cmp("b4 busy cycles", 8'(nbusy), 8'd24);
`else
        cmp("b4 busy cycles", 8'(nbusy), 8'd20);
`endif

        // DIV=1, 0x1B then 0xE4 with in_valid held; second byte taken in the done cycle
        idat[1] = 8'h1B;
        iv[1]   = 1'b1;
        push_frame(1, 8'h1B);
        c = 0; d1 = -1; d2 = -1; nfr = 1;
        while (q1.size() > 0) begin
            step(1, "b2b", e);
            c++;
            if (c == 1) idat[1] = 8'hE4;
            if (dn[1] === 1'b1) begin
                if (d1 < 0) d1 = c;
                else        d2 = c;
            end
            if (e.done && nfr == 1) begin
                push_frame(1, 8'hE4);
                nfr = 2;
            end
            if (c == qsize(1) - qsize(1) + d1 + 1 && d1 > 0) iv[1] = 1'b0;
        end
`ifdef DIBIT_TX_PARITY_EN
        cmp("b2b done spacing", 8'(d2 - d1), 8'd7);
`else
        cmp("b2b done spacing", 8'(d2 - d1), 8'd6);
`endif

        // DIV=4, 0x5A while in_data and in_valid churn during the frame
        idat[0] = 8'h5A;
        iv[0]   = 1'b1;
        push_frame(0, 8'h5A);
        while (q0.size() > 0) begin
            step(0, "5a churn", e);
            idat[0] = 8'hFF;
            iv[0]   = (q0.size() > 0) ? ~iv[0] : 1'b0;
        end

        // DIV=4, reset asserted during the second data symbol of 0xB4
        idat[0] = 8'hB4;
        iv[0]   = 1'b1;
        push_frame(0, 8'hB4);
        repeat (10) begin
            step(0, "b4 pre-rst", e);
            iv[0] = 1'b0;
        end
        #2;
        rst = 1'b1;
        #1;
        cmp("async rst line", {6'd0, xo[0], zo[0]}, 8'h00);
        cmp("async rst busy", {7'd0, bsy[0]}, 8'h00);
        cmp("async rst in_ready", {7'd0, rdy[0]}, 8'h01);
        cmp("async rst done", {7'd0, dn[0]}, 8'h00);
        q0.delete();
        #1;
        rst = 1'b0;
        push_idle(0, 3);
        repeat (3) step(0, "post-rst idle", e);
        idat[0] = 8'h5A;
        iv[0]   = 1'b1;
        push_frame(0, 8'h5A);
        while (q0.size() > 0) begin
            step(0, "post-rst 5a", e);
            iv[0] = 1'b0;
        end

        // DIV=4, one-cycle in_valid pulse exactly in the done cycle
        idat[0] = 8'h3C;
        iv[0]   = 1'b1;
        push_frame(0, 8'h3C);
        nfr = 1;
        while (q0.size() > 0) begin
            step(0, "coincide", e);
            iv[0] = 1'b0;
            if (e.done && nfr == 1) begin
                idat[0] = 8'hC3;
                iv[0]   = 1'b1;
                push_frame(0, 8'hC3);
                nfr = 2;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
